seg_scan_ctrl: RTL

- Time-multiplexes one shared BCD-to-7-segment decoder across DIGITS common-anode digits.
- Holds a shadow and an active digit register file. Host writes land in the shadow file and are committed to the active file tear-free at frame boundaries.
- Sequences decoder input, anode enables and dead-time blanking.
- Sits between the host/register interface and the segment decoder plus display pins.

---
 rtl/seg_scan_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexes one shared BCD-to-7-segment decoder across
// DIGITS common-anode digits, with tear-free shadow->active commits at frame
// boundaries, dead-time blanking between slots and leading-zero blanking.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   enable       1 = scanning, 0 = display dark
//   lzb_en       leading-zero blanking enable
//   wr_en        write strobe into the shadow file
//   wr_addr      shadow digit index (values >= DIGITS ignored)
//   wr_data      BCD/hex nibble to write
//   commit       request shadow->active copy (level-sampled)
//   commit_done  one-cycle pulse, high the cycle after the copy edge
//   bcd          nibble to the shared decoder
//   blank        1 = decoder output forced off
//   an_n         active-low anode enables, at most one low
//   digit_idx    digit currently in its slot
module seg_scan_ctrl #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned PRESCALE = 1000,
    parameter int unsigned BLANK    = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      lzb_en,
    input  logic                      wr_en,
    input  logic [$clog2(DIGITS)-1:0] wr_addr,
    input  logic [3:0]                wr_data,
    input  logic                      commit,
    output logic                      commit_done,
    output logic [3:0]                bcd,
    output logic                      blank,
    output logic [DIGITS-1:0]         an_n,
    output logic [$clog2(DIGITS)-1:0] digit_idx
);

    localparam int unsigned   AW         = $clog2(DIGITS);
    localparam int unsigned   CW         = $clog2(PRESCALE);
    localparam logic [AW-1:0] LAST_DIGIT = AW'(DIGITS - 1);
    localparam logic [CW-1:0] LAST_CNT   = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] LAST_DEAD  = CW'(BLANK - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEAD,
        ST_ON
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [AW-1:0]          idx_q, idx_d;
    logic                   pending_q, pending_d;
    logic [DIGITS-1:0][3:0] shadow_q;
    logic [DIGITS-1:0][3:0] active_q, active_d;
    logic                   frame_wrap;
    logic                   copy;
    logic                   wr_hit;
    logic                   lz;
    logic [DIGITS-1:0]      an_n_d;
    logic                   blank_d;
    logic [3:0]             bcd_d;

    assign digit_idx = idx_q;
    assign wr_hit    = wr_en && (32'(wr_addr) < DIGITS);

    // Scan sequencer: IDLE -> DEAD (BLANK cycles) -> ON (rest of slot) -> next digit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (enable) begin
                    state_d = ST_DEAD;
                end
            end
            ST_DEAD: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_DEAD) begin
                    state_d = ST_ON;
                end
            end
            ST_ON: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = ST_DEAD;
                    idx_d   = (idx_q == LAST_DIGIT) ? '0 : idx_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Disable overrides everything and parks the scan at digit 0.
        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end
    end

    // Commit happens on the last-digit -> digit-0 wrap, or any cycle spent idle.
    assign frame_wrap = enable && (state_q == ST_ON) && (cnt_q == LAST_CNT) &&
                        (idx_q == LAST_DIGIT);
    assign copy       = pending_q && (frame_wrap || (state_q == ST_IDLE));
    assign pending_d  = copy ? commit : (pending_q | commit);
    assign active_d   = copy ? shadow_q : active_q;

    // Outputs are registered from next-state values so they line up with state_q.
    always_comb begin
        lz = lzb_en && (idx_d != '0);
        for (int unsigned j = 0; j < DIGITS; j++) begin
            if ((AW'(j) >= idx_d) && (active_d[j] != 4'd0)) begin
                lz = 1'b0;
            end
        end
        an_n_d  = '1;
        blank_d = 1'b1;
        bcd_d   = active_d[idx_d];
        if (state_d == ST_ON) begin
            an_n_d[idx_d] = 1'b0;
            blank_d       = lz;
        end
    end

    // State, register files and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            pending_q   <= 1'b0;
            shadow_q    <= '0;
            active_q    <= '0;
            an_n        <= '1;
            blank       <= 1'b1;
            bcd         <= 4'd0;
            commit_done <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            pending_q   <= pending_d;
            active_q    <= active_d;
            an_n        <= an_n_d;
            blank       <= blank_d;
            bcd         <= bcd_d;
            commit_done <= copy;
            if (wr_hit) begin
                shadow_q[wr_addr] <= wr_data;
            end
        end
    end

endmodule
